// File: rtl/rom_fetch_arbiter_if.sv
// rom_fetch_arbiter_if
//   Bundles the requester handshakes, the tagged read-return path and the
//   program ROM port of rom_fetch_arbiter.
//   slave  : the arbiter side (samples requests and rom_q, drives grants,
//            read tags, rd_data and rom_address).
//   master : the environment side (requesters plus the ROM itself).
//   Signals:
//     r0_req/r0_addr, r1_req/r1_addr   burst requests and line addresses
//     r0_gnt/r1_gnt                    grant pulse, first issue cycle
//     r0_valid/r1_valid                rd_data belongs to this requester
//     r0_done/r1_done                  last word of the burst
//     rd_offset                        word offset of rd_data within its line
//     rd_data                          returned ROM word
//     rom_address                      ROM address (registered by the ROM)
//     rom_q                            ROM read data, one cycle after address
interface rom_fetch_arbiter_if #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 8
);
    localparam int OFF_W = $clog2(BURST_LEN);

    logic              r0_req;
    logic [ADDR_W-1:0] r0_addr;
    logic              r1_req;
    logic [ADDR_W-1:0] r1_addr;
    logic              r0_gnt;
    logic              r1_gnt;
    logic              r0_valid;
    logic              r1_valid;
    logic              r0_done;
    logic              r1_done;
    logic [OFF_W-1:0]  rd_offset;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] rom_address;
    logic [DATA_W-1:0] rom_q;

    modport slave (
        input  r0_req, r0_addr, r1_req, r1_addr, rom_q,
        output r0_gnt, r1_gnt, r0_valid, r1_valid, r0_done, r1_done,
               rd_offset, rd_data, rom_address
    );

    modport master (
        output r0_req, r0_addr, r1_req, r1_addr, rom_q,
        input  r0_gnt, r1_gnt, r0_valid, r1_valid, r0_done, r1_done,
               rd_offset, rd_data, rom_address
    );
endinterface

// File: rtl/rom_fetch_arbiter.sv
// rom_fetch_arbiter
//   Shares the single synchronous program ROM port between the instruction
//   cache refill (requester 0) and the data/table reader (requester 1).
//   Whole line bursts of BURST_LEN words are granted; bursts run back to
//   back, and ties alternate so neither side starves.
//   Ports:
//     clk           single rising-edge clock
//     sync_reset_n  synchronous active-low reset
//     bus           rom_fetch_arbiter_if.slave: requests, grants, tagged
//                   read return and the ROM address/data port
module rom_fetch_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 8
) (
    input logic                clk,
    input logic                sync_reset_n,
    rom_fetch_arbiter_if.slave bus
);
    localparam int OFF_W = $clog2(BURST_LEN);
    localparam int TAG_W = ADDR_W - OFF_W;
    localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(BURST_LEN - 1);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t            state_q, state_d;
    logic [OFF_W-1:0]  cnt_q, cnt_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              owner_q, owner_d;
    logic              last_owner_q, last_owner_d;
    logic [ADDR_W-1:0] last_addr_q;

    // Read pipeline: what was issued last cycle is what rom_q carries now.
    logic              iss_v;
    logic              iss_owner;
    logic [OFF_W-1:0]  iss_off;

    logic              arb_point;
    logic              pick;
    logic [ADDR_W-1:0] issue_addr;
    logic              unused_line_offsets;

    // The line offset is the counter itself, so an issue can never carry
    // into the tag and a burst stays inside its line.
    assign issue_addr = {tag_q, cnt_q};

    // Requesters present line addresses; the word bits are don't-care.
    assign unused_line_offsets = ^{bus.r0_addr[OFF_W-1:0], bus.r1_addr[OFF_W-1:0]};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tag_d        = tag_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;

        // Requests are only looked at when idle or on the last issue of a
        // burst, which lets the next burst start without a bubble.
        arb_point = (state_q == IDLE) || (cnt_q == LAST_OFF);

        if (bus.r0_req && bus.r1_req) begin
            pick = ~last_owner_q;
        end else begin
            pick = bus.r1_req;
        end

        if (state_q == BURST) begin
            cnt_d = cnt_q + OFF_W'(1);
        end

        if (arb_point) begin
            if (bus.r0_req || bus.r1_req) begin
                state_d      = BURST;
                cnt_d        = '0;
                owner_d      = pick;
                last_owner_d = pick;
                tag_d        = pick ? bus.r1_addr[ADDR_W-1:OFF_W]
                                    : bus.r0_addr[ADDR_W-1:OFF_W];
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!sync_reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            tag_q        <= '0;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            last_addr_q  <= '0;
            iss_v        <= 1'b0;
            iss_owner    <= 1'b0;
            iss_off      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tag_q        <= tag_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            if (state_q == BURST) begin
                last_addr_q <= issue_addr;
            end
            iss_v        <= (state_q == BURST);
            iss_owner    <= owner_q;
            iss_off      <= cnt_q;
        end
    end

    assign bus.r0_gnt      = (state_q == BURST) && (cnt_q == '0) && !owner_q;
    assign bus.r1_gnt      = (state_q == BURST) && (cnt_q == '0) &&  owner_q;
    assign bus.rom_address = (state_q == BURST) ? issue_addr : last_addr_q;

    assign bus.r0_valid  = iss_v && !iss_owner;
    assign bus.r1_valid  = iss_v &&  iss_owner;
    assign bus.r0_done   = bus.r0_valid && (iss_off == LAST_OFF);
    assign bus.r1_done   = bus.r1_valid && (iss_off == LAST_OFF);
    assign bus.rd_offset = iss_off;
    assign bus.rd_data   = bus.rom_q;
endmodule

// File: tb/tb_rom_fetch_arbiter.sv
module tb_rom_fetch_arbiter;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int BL     = 8;
    localparam int NC     = 4096;

    logic clk = 1'b0;
    logic sync_reset_n;

    rom_fetch_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BL)) bus ();

    rom_fetch_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BL)) dut (
        .clk          (clk),
        .sync_reset_n (sync_reset_n),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: address registered, data out one cycle later.
    logic [7:0] rom_mem [256];
    always @(posedge clk) bus.rom_q <= rom_mem[bus.rom_address];

    int errors = 0;
    int checks = 0;

    // Expected per-cycle behaviour for the randomized run.
    bit         e_g0 [NC];
    bit         e_g1 [NC];
    bit         e_v0 [NC];
    bit         e_v1 [NC];
    bit         e_d0 [NC];
    bit         e_d1 [NC];
    bit         e_iss [NC];
    logic [7:0] e_addr [NC];
    logic [2:0] e_off [NC];
    logic [7:0] e_raddr [NC];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        sync_reset_n = 1'b0;
        bus.r0_req   = 1'b0;
        bus.r1_req   = 1'b0;
        tick();
        tick();
        sync_reset_n = 1'b1;
    endtask

    task automatic test_reset();
        sync_reset_n = 1'b0;
        bus.r0_req = 1'b1; bus.r0_addr = 8'h10;
        bus.r1_req = 1'b1; bus.r1_addr = 8'h20;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({bus.r0_gnt, bus.r1_gnt, bus.r0_valid, bus.r1_valid, bus.r0_done, bus.r1_done} !== 6'b0) begin
                errors++;
                $display("FAIL reset_flags got=%b exp=000000", {bus.r0_gnt, bus.r1_gnt, bus.r0_valid, bus.r1_valid, bus.r0_done, bus.r1_done});
            end
            checks++;
            if (bus.rom_address !== 8'h00) begin
                errors++;
                $display("FAIL reset_addr got=%h exp=00", bus.rom_address);
            end
            checks++;
            if (bus.rd_offset !== 3'd0) begin
                errors++;
                $display("FAIL reset_offset got=%0d exp=0", bus.rd_offset);
            end
            tick();
        end
        sync_reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.r0_gnt !== 1'b0) begin
            errors++;
            $display("FAIL reset_early_gnt got=%b exp=0", bus.r0_gnt);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({bus.r0_gnt, bus.r1_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release_gnt got=%b exp=10", {bus.r0_gnt, bus.r1_gnt});
        end
    endtask

    task automatic test_single_burst();
        logic [7:0] ea;
        do_reset();
        bus.r1_req = 1'b1; bus.r1_addr = 8'h5B;
        for (int j = 1; j <= 10; j++) begin
            tick();
            if (j == 1) bus.r1_req = 1'b0;
            @(negedge clk);
            checks++;
            if (bus.r1_gnt !== (j == 1)) begin
                errors++;
                $display("FAIL single_gnt j=%0d got=%b exp=%b", j, bus.r1_gnt, (j == 1));
            end
            ea = (j <= 8) ? 8'(8'h58 + j - 1) : 8'h5F;
            checks++;
            if (bus.rom_address !== ea) begin
                errors++;
                $display("FAIL single_addr j=%0d got=%h exp=%h", j, bus.rom_address, ea);
            end
            checks++;
            if ({bus.r0_valid, bus.r1_valid} !== {1'b0, (j >= 2 && j <= 9)}) begin
                errors++;
                $display("FAIL single_valid j=%0d got=%b exp=%b", j, {bus.r0_valid, bus.r1_valid}, {1'b0, (j >= 2 && j <= 9)});
            end
            checks++;
            if (bus.r1_done !== (j == 9)) begin
                errors++;
                $display("FAIL single_done j=%0d got=%b exp=%b", j, bus.r1_done, (j == 9));
            end
            if (j >= 2 && j <= 9) begin
                ea = 8'(8'h58 + j - 2);
                checks++;
                if (bus.rd_offset !== 3'(j - 2)) begin
                    errors++;
                    $display("FAIL single_offset j=%0d got=%0d exp=%0d", j, bus.rd_offset, j - 2);
                end
                checks++;
                if (bus.rd_data !== rom_mem[ea]) begin
                    errors++;
                    $display("FAIL single_data j=%0d got=%h exp=%h", j, bus.rd_data, rom_mem[ea]);
                end
            end
        end
    endtask

    task automatic test_contention();
        logic [7:0] ea;
        bit eg0, eg1, ed0, ed1;
        sync_reset_n = 1'b0;
        bus.r0_req = 1'b1; bus.r0_addr = 8'h13;
        bus.r1_req = 1'b1; bus.r1_addr = 8'h2E;
        tick();
        tick();
        sync_reset_n = 1'b1;
        for (int j = 1; j <= 33; j++) begin
            tick();
            @(negedge clk);
            eg0 = (j % 16 == 1);
            eg1 = (j % 16 == 9);
            ed0 = (j % 16 == 9);
            ed1 = (j >= 17) && (j % 16 == 1);
            ea  = 8'((((j - 1) / 8) % 2 == 0 ? 8'h10 : 8'h28) + (j - 1) % 8);
            checks++;
            if ({bus.r0_gnt, bus.r1_gnt} !== {eg0, eg1}) begin
                errors++;
                $display("FAIL cont_gnt j=%0d got=%b exp=%b", j, {bus.r0_gnt, bus.r1_gnt}, {eg0, eg1});
            end
            checks++;
            if ({bus.r0_done, bus.r1_done} !== {ed0, ed1}) begin
                errors++;
                $display("FAIL cont_done j=%0d got=%b exp=%b", j, {bus.r0_done, bus.r1_done}, {ed0, ed1});
            end
            checks++;
            if (bus.rom_address !== ea) begin
                errors++;
                $display("FAIL cont_addr j=%0d got=%h exp=%h", j, bus.rom_address, ea);
            end
        end
    endtask

    task automatic test_late_request();
        do_reset();
        bus.r0_req = 1'b1; bus.r0_addr = 8'h44;
        for (int j = 1; j <= 10; j++) begin
            tick();
            if (j == 1) bus.r0_req = 1'b0;
            if (j == 4) begin
                bus.r1_req = 1'b1; bus.r1_addr = 8'h83;
            end
            if (j == 10) bus.r1_req = 1'b0;
            @(negedge clk);
            checks++;
            if (bus.r1_gnt !== (j == 9)) begin
                errors++;
                $display("FAIL late_gnt j=%0d got=%b exp=%b", j, bus.r1_gnt, (j == 9));
            end
            checks++;
            if (bus.r1_valid !== (j == 10)) begin
                errors++;
                $display("FAIL late_valid j=%0d got=%b exp=%b", j, bus.r1_valid, (j == 10));
            end
            checks++;
            if (bus.r0_done !== (j == 9)) begin
                errors++;
                $display("FAIL late_r0_done j=%0d got=%b exp=%b", j, bus.r0_done, (j == 9));
            end
            if (j == 9) begin
                checks++;
                if (bus.rom_address !== 8'h80) begin
                    errors++;
                    $display("FAIL late_addr got=%h exp=80", bus.rom_address);
                end
            end
            if (j == 10) begin
                checks++;
                if (bus.rd_offset !== 3'd0 || bus.rd_data !== rom_mem[8'h80]) begin
                    errors++;
                    $display("FAIL late_first_word got=%0d/%h exp=0/%h", bus.rd_offset, bus.rd_data, rom_mem[8'h80]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        bus.r0_req = 1'b1; bus.r0_addr = 8'h30;
        for (int j = 1; j <= 8; j++) begin
            tick();
            if (j == 1) bus.r0_req = 1'b0;
            if (j == 5) begin
                sync_reset_n = 1'b0;
                bus.r0_req = 1'b1; bus.r0_addr = 8'h30;
                bus.r1_req = 1'b1; bus.r1_addr = 8'h90;
            end
            if (j == 7) sync_reset_n = 1'b1;
            @(negedge clk);
            if (j == 5) begin
                checks++;
                if (bus.r0_valid !== 1'b1 || bus.rd_offset !== 3'd3) begin
                    errors++;
                    $display("FAIL midrst_before got=%b/%0d exp=1/3", bus.r0_valid, bus.rd_offset);
                end
            end
            if (j == 6 || j == 7) begin
                checks++;
                if ({bus.r0_valid, bus.r0_done, bus.r0_gnt, bus.r1_gnt} !== 4'b0) begin
                    errors++;
                    $display("FAIL midrst_quiet j=%0d got=%b exp=0000", j, {bus.r0_valid, bus.r0_done, bus.r0_gnt, bus.r1_gnt});
                end
                checks++;
                if (bus.rom_address !== 8'h00) begin
                    errors++;
                    $display("FAIL midrst_addr j=%0d got=%h exp=00", j, bus.rom_address);
                end
            end
            if (j == 8) begin
                checks++;
                if ({bus.r0_gnt, bus.r1_gnt} !== 2'b10) begin
                    errors++;
                    $display("FAIL midrst_tie got=%b exp=10", {bus.r0_gnt, bus.r1_gnt});
                end
            end
        end
        bus.r0_req = 1'b0;
        bus.r1_req = 1'b0;
    endtask

    task automatic test_line_boundary();
        logic [7:0] ea;
        do_reset();
        bus.r0_req = 1'b1; bus.r0_addr = 8'hFF;
        for (int j = 1; j <= 9; j++) begin
            tick();
            if (j == 1) bus.r0_req = 1'b0;
            @(negedge clk);
            ea = (j <= 8) ? 8'(8'hF8 + j - 1) : 8'hFF;
            checks++;
            if (bus.rom_address !== ea) begin
                errors++;
                $display("FAIL line_addr j=%0d got=%h exp=%h", j, bus.rom_address, ea);
            end
            checks++;
            if (bus.r0_done !== (j == 9)) begin
                errors++;
                $display("FAIL line_done j=%0d got=%b exp=%b", j, bus.r0_done, (j == 9));
            end
        end
    endtask

    // Transaction-level model: a grant decided in cycle c occupies the port
    // for cycles c+1..c+BL and returns words in c+2..c+BL+1.
    task automatic test_random(input int ncyc);
        int         rst_left = 0;
        int         o;
        int         b;
        int         g;
        bit         pend [2];
        logic [7:0] pa [2];
        int         m_last_issue = -1;
        bit         m_last_owner = 1'b1;
        logic [7:0] m_hold = 8'h00;
        logic [7:0] ea;
        pend[0] = 1'b0; pend[1] = 1'b0;
        pa[0] = 8'h00; pa[1] = 8'h00;
        for (int i = 0; i < NC; i++) begin
            e_g0[i] = 0; e_g1[i] = 0; e_v0[i] = 0; e_v1[i] = 0;
            e_d0[i] = 0; e_d1[i] = 0; e_iss[i] = 0;
            e_addr[i] = '0; e_off[i] = '0; e_raddr[i] = '0;
        end
        do_reset();
        for (int c = 0; c < ncyc; c++) begin
            if (c > 0) tick();
            if (rst_left == 0 && $urandom_range(0, 149) == 0) rst_left = $urandom_range(1, 3);
            sync_reset_n = (rst_left == 0);
            if (rst_left > 0) rst_left--;
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && $urandom_range(0, 2) == 0) begin
                    pend[r] = 1'b1;
                    pa[r]   = 8'($urandom);
                end
            end
            bus.r0_req = pend[0]; bus.r0_addr = pa[0];
            bus.r1_req = pend[1]; bus.r1_addr = pa[1];
            @(negedge clk);
            checks++;
            if ({bus.r0_gnt, bus.r1_gnt} !== {e_g0[c], e_g1[c]}) begin
                errors++;
                $display("FAIL rnd_gnt c=%0d got=%b exp=%b", c, {bus.r0_gnt, bus.r1_gnt}, {e_g0[c], e_g1[c]});
            end
            checks++;
            if ({bus.r0_valid, bus.r1_valid} !== {e_v0[c], e_v1[c]}) begin
                errors++;
                $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, {bus.r0_valid, bus.r1_valid}, {e_v0[c], e_v1[c]});
            end
            checks++;
            if ({bus.r0_done, bus.r1_done} !== {e_d0[c], e_d1[c]}) begin
                errors++;
                $display("FAIL rnd_done c=%0d got=%b exp=%b", c, {bus.r0_done, bus.r1_done}, {e_d0[c], e_d1[c]});
            end
            ea = e_iss[c] ? e_addr[c] : m_hold;
            if (e_iss[c]) m_hold = e_addr[c];
            checks++;
            if (bus.rom_address !== ea) begin
                errors++;
                $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, bus.rom_address, ea);
            end
            if (e_v0[c] || e_v1[c]) begin
                checks++;
                if (bus.rd_offset !== e_off[c]) begin
                    errors++;
                    $display("FAIL rnd_offset c=%0d got=%0d exp=%0d", c, bus.rd_offset, e_off[c]);
                end
                checks++;
                if (bus.rd_data !== rom_mem[e_raddr[c]]) begin
                    errors++;
                    $display("FAIL rnd_data c=%0d got=%h exp=%h", c, bus.rd_data, rom_mem[e_raddr[c]]);
                end
            end
            if (!sync_reset_n) begin
                for (int k = c + 1; k <= c + BL + 1; k++) begin
                    e_g0[k] = 0; e_g1[k] = 0; e_v0[k] = 0; e_v1[k] = 0;
                    e_d0[k] = 0; e_d1[k] = 0; e_iss[k] = 0;
                end
                m_last_issue = -1;
                m_last_owner = 1'b1;
                m_hold       = 8'h00;
            end else if (m_last_issue <= c && (pend[0] || pend[1])) begin
                if (pend[0] && pend[1]) o = m_last_owner ? 0 : 1;
                else o = pend[1] ? 1 : 0;
                b = int'(pa[o]) / BL * BL;
                g = c + 1;
                if (o == 1) e_g1[g] = 1; else e_g0[g] = 1;
                for (int k = 0; k < BL; k++) begin
                    e_iss[g + k]       = 1;
                    e_addr[g + k]      = 8'(b + k);
                    e_off[g + 1 + k]   = 3'(k);
                    e_raddr[g + 1 + k] = 8'(b + k);
                    if (o == 1) e_v1[g + 1 + k] = 1; else e_v0[g + 1 + k] = 1;
                end
                if (o == 1) e_d1[g + BL] = 1; else e_d0[g + BL] = 1;
                m_last_issue = g + BL - 1;
                m_last_owner = (o == 1);
                pend[o]      = 1'b0;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        sync_reset_n = 1'b0;
        bus.r0_req = 1'b0; bus.r0_addr = 8'h00;
        bus.r1_req = 1'b0; bus.r1_addr = 8'h00;
        for (int i = 0; i < 256; i++) rom_mem[i] = 8'($urandom);
        test_reset();
        test_single_burst();
        test_contention();
        test_late_request();
        test_reset_mid_burst();
        test_line_boundary();
        test_random(1500);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
